// File: rtl/sd_read_arbiter.sv
// rtl/sd_read_arbiter.sv - shares one SD block-read controller between two clients
// Round-robin grant, per-client request latch, byte routing, watchdog and byte-count supervision.
module sd_read_arbiter #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT     = 1023,
  parameter int TO_W        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_start,
  input  logic [31:0] c0_address,
  output logic [7:0]  c0_data,
  output logic        c0_valid,
  output logic        c0_available,
  input  logic        c1_start,
  input  logic [31:0] c1_address,
  output logic [7:0]  c1_data,
  output logic        c1_valid,
  output logic        c1_available,
  output logic        SDctrl_start,
  output logic [31:0] SDctrl_address,
  input  logic [7:0]  SDctrl_data,
  input  logic        SDctrl_valid,
  input  logic        SDctrl_available,
  output logic [1:0]  grant,
  output logic [1:0]  pend,
  output logic        err_timeout,
  output logic        err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [9:0]      BYTE_MAX  = 10'd1023;
  localparam logic [9:0]      BLOCK_CNT = 10'(BLOCK_BYTES);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      pend_q, pend_d;
  logic [31:0]     addr0_q, addr0_d;
  logic [31:0]     addr1_q, addr1_d;
  logic [31:0]     sd_addr_q, sd_addr_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [9:0]      bytes_q, bytes_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_count_q, err_count_d;
  logic            abandon_q, abandon_d;
  logic            avail0_q, avail0_d;
  logic            avail1_q, avail1_d;
  logic            sel;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    addr0_d       = addr0_q;
    addr1_d       = addr1_q;
    sd_addr_d     = sd_addr_q;
    grant_d       = grant_q;
    last_d        = last_q;
    wd_d          = wd_q;
    bytes_d       = bytes_q;
    err_timeout_d = err_timeout_q;
    err_count_d   = err_count_q;
    abandon_d     = abandon_q;
    // Client 1 wins when it is the only one pending, or when both pend and 0 went last.
    sel           = pend_q[1] && (!pend_q[0] || !last_q);

    if (c0_start && !pend_q[0] && !grant_q[0]) begin
      pend_d[0] = 1'b1;
      addr0_d   = c0_address;
    end
    if (c1_start && !pend_q[1] && !grant_q[1]) begin
      pend_d[1] = 1'b1;
      addr1_d   = c1_address;
    end

    case (state_q)
      S_IDLE: begin
        if ((pend_q != 2'b00) && SDctrl_available) begin
          grant_d     = sel ? 2'b10 : 2'b01;
          sd_addr_d   = sel ? addr1_q : addr0_q;
          pend_d[sel] = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d      = '0;
        bytes_d   = '0;
        abandon_d = 1'b0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!SDctrl_available) begin
          state_d = S_BUSY;
        end else if (wd_q == TO_LAST) begin
          err_timeout_d = 1'b1;
          abandon_d     = 1'b1;
          state_d       = S_DONE;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_BUSY: begin
        if (SDctrl_valid && (bytes_q != BYTE_MAX)) begin
          bytes_d = bytes_q + 10'd1;
        end
        if (SDctrl_available) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!abandon_q && (bytes_q != BLOCK_CNT)) begin
          err_count_d = 1'b1;
        end
        grant_d = 2'b00;
        last_d  = grant_q[1];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    avail0_d = (state_q == S_IDLE) && !pend_q[0] && SDctrl_available && !c0_start;
    avail1_d = (state_q == S_IDLE) && !pend_q[1] && SDctrl_available && !c1_start;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pend_q        <= 2'b00;
      addr0_q       <= '0;
      addr1_q       <= '0;
      sd_addr_q     <= '0;
      grant_q       <= 2'b00;
      last_q        <= 1'b1;
      wd_q          <= '0;
      bytes_q       <= '0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 1'b0;
      abandon_q     <= 1'b0;
      avail0_q      <= 1'b0;
      avail1_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      addr0_q       <= addr0_d;
      addr1_q       <= addr1_d;
      sd_addr_q     <= sd_addr_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      wd_q          <= wd_d;
      bytes_q       <= bytes_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
      abandon_q     <= abandon_d;
      avail0_q      <= avail0_d;
      avail1_q      <= avail1_d;
    end
  end

  // Bytes reach a client only while it owns a transaction the controller has accepted.
  assign c0_valid       = (state_q == S_BUSY) && grant_q[0] && SDctrl_valid;
  assign c1_valid       = (state_q == S_BUSY) && grant_q[1] && SDctrl_valid;
  assign c0_data        = ((state_q == S_BUSY) && grant_q[0]) ? SDctrl_data : 8'h00;
  assign c1_data        = ((state_q == S_BUSY) && grant_q[1]) ? SDctrl_data : 8'h00;
  assign c0_available   = avail0_q;
  assign c1_available   = avail1_q;
  assign SDctrl_start   = (state_q == S_ISSUE);
  assign SDctrl_address = sd_addr_q;
  assign grant          = grant_q;
  assign pend           = pend_q;
  assign err_timeout    = err_timeout_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb/tb_sd_read_arbiter.sv - directed bench for sd_read_arbiter
// Behavioural SD controller model plus per-client byte and grant-order monitors.
module tb_sd_read_arbiter;
  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c0_start = 1'b0, c1_start = 1'b0;
  logic [31:0] c0_address = '0, c1_address = '0;
  logic [7:0]  c0_data, c1_data;
  logic        c0_valid, c1_valid, c0_available, c1_available;
  logic        SDctrl_start;
  logic [31:0] SDctrl_address;
  logic [7:0]  SDctrl_data;
  logic        SDctrl_valid, SDctrl_available;
  logic [1:0]  grant, pend;
  logic        err_timeout, err_count;

  int checks = 0;
  int errors = 0;

  sd_read_arbiter #(.BLOCK_BYTES(512), .TIMEOUT(TIMEOUT), .TO_W(10)) dut (
    .clk(clk), .rst(rst),
    .c0_start(c0_start), .c0_address(c0_address), .c0_data(c0_data),
    .c0_valid(c0_valid), .c0_available(c0_available),
    .c1_start(c1_start), .c1_address(c1_address), .c1_data(c1_data),
    .c1_valid(c1_valid), .c1_available(c1_available),
    .SDctrl_start(SDctrl_start), .SDctrl_address(SDctrl_address),
    .SDctrl_data(SDctrl_data), .SDctrl_valid(SDctrl_valid),
    .SDctrl_available(SDctrl_available),
    .grant(grant), .pend(pend), .err_timeout(err_timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SD controller model: idle-high available, drops it after start, streams nbytes.
  int   nbytes    = 512;
  logic hold_mode = 1'b0;
  logic sd_busy   = 1'b0;
  initial begin
    SDctrl_available = 1'b1;
    SDctrl_valid     = 1'b0;
    SDctrl_data      = 8'h00;
    forever begin
      @(negedge clk);
      if (SDctrl_start === 1'b1 && !hold_mode) begin
        sd_busy = 1'b1;
        @(posedge clk); #1 SDctrl_available = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
          @(posedge clk); #1;
          SDctrl_valid = 1'b1;
          SDctrl_data  = 8'(i + 1);
        end
        @(posedge clk); #1;
        SDctrl_valid     = 1'b0;
        SDctrl_available = 1'b1;
        sd_busy          = 1'b0;
      end
    end
  end

  int         cnt0 = 0, cnt1 = 0;
  logic [1:0] grant_prev = 2'b00;
  logic [1:0] gseq[$];
  always @(negedge clk) begin
    if (c0_valid === 1'b1) cnt0++;
    if (c1_valid === 1'b1) cnt1++;
    if (grant != 2'b00 && grant_prev == 2'b00) gseq.push_back(grant);
    grant_prev = grant;
  end

  task automatic req(input int c, input logic [31:0] a);
    @(posedge clk); #1;
    if (c == 0) begin c0_start = 1'b1; c0_address = a; end
    else        begin c1_start = 1'b1; c1_address = a; end
    @(posedge clk); #1;
    if (c == 0) c0_start = 1'b0;
    else        c1_start = 1'b0;
  endtask

  task automatic wait_avail(input int c, input int limit, input string tag);
    int n = 0;
    while (((c == 0) ? c0_available : c1_available) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (c == 0) ? c0_available : c1_available, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  int b0, b1, gb, n;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_pend", pend, 2'b00);
    chk("rst_start", SDctrl_start, 1'b0);
    chk("rst_addr", SDctrl_address, 32'h0);
    chk("rst_avail0", c0_available, 1'b0);
    chk("rst_errs", {err_timeout, err_count}, 2'b00);
    #1 rst = 1'b1;
    wait_avail(0, 10, "t0_avail_up");

    // Single client 0 read
    b0 = cnt0; b1 = cnt1;
    @(posedge clk); #1 c0_start = 1'b1; c0_address = 32'h0000_0200;
    @(posedge clk); #1 c0_start = 1'b0;
    @(negedge clk);
    chk("t1_avail_low", c0_available, 1'b0);
    chk("t1_pend", pend, 2'b01);
    chk("t1_start_early", SDctrl_start, 1'b0);
    @(negedge clk);
    chk("t1_start", SDctrl_start, 1'b1);
    chk("t1_addr", SDctrl_address, 32'h200);
    chk("t1_grant", grant, 2'b01);
    wait_avail(0, 3000, "t1_avail_back");
    chk("t1_bytes0", cnt0 - b0, 512);
    chk("t1_bytes1", cnt1 - b1, 0);
    chk("t1_errs", {err_timeout, err_count}, 2'b00);

    // Simultaneous starts right after reset
    do_reset();
    wait_avail(0, 10, "t2_av0");
    gb = gseq.size(); b0 = cnt0; b1 = cnt1;
    @(posedge clk); #1;
    c0_start = 1'b1; c0_address = 32'h1000;
    c1_start = 1'b1; c1_address = 32'h2400;
    @(posedge clk); #1 c0_start = 1'b0; c1_start = 1'b0;
    @(negedge clk);
    chk("t2_pend_both", pend, 2'b11);
    @(negedge clk);
    chk("t2_grant0", grant, 2'b01);
    chk("t2_addr0", SDctrl_address, 32'h1000);
    n = 0;
    while (cnt0 - b0 < 10 && n < 200) begin @(negedge clk); n++; end
    chk("t2_pend_during", pend, 2'b10);
    n = 0;
    while (grant !== 2'b10 && n < 3000) begin @(negedge clk); n++; end
    chk("t2_grant1", grant, 2'b10);
    chk("t2_addr1", SDctrl_address, 32'h2400);
    wait_avail(1, 3000, "t2_av1_back");
    chk("t2_nseq", gseq.size() - gb, 2);
    if (gseq.size() >= gb + 2) begin
      chk("t2_seq0", gseq[gb], 2'b01);
      chk("t2_seq1", gseq[gb+1], 2'b10);
    end
    chk("t2_bytes", {16'(cnt0 - b0), 16'(cnt1 - b1)}, {16'd512, 16'd512});

    // Continuous contention, 6 transactions
    gb = gseq.size();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          wait_avail(0, 3000, "t3_av0");
          req(0, 32'h1_0000 + 32'(k * 512));
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_avail(1, 3000, "t3_av1");
          req(1, 32'h2_0000 + 32'(k * 512));
        end
      end
    join
    wait_avail(0, 5000, "t3_end0");
    wait_avail(1, 5000, "t3_end1");
    chk("t3_nseq", gseq.size() - gb, 6);
    for (int i = gb + 1; i < gb + 6 && i < gseq.size(); i++)
      chk("t3_alternate", gseq[i] ^ gseq[i-1], 2'b11);

    // Watchdog
    hold_mode = 1'b1;
    req(1, 32'h4000);
    n = 0;
    while (SDctrl_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t4_start", SDctrl_start, 1'b1);
    n = 0;
    while (err_timeout !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
    chk("t4_to_cycles", n, TIMEOUT + 1);
    chk("t4_err_to", err_timeout, 1'b1);
    wait_avail(1, 20, "t4_av1_back");
    hold_mode = 1'b0;
    b0 = cnt0;
    req(0, 32'h600);
    wait_avail(0, 3000, "t4_next_av");
    chk("t4_next_bytes", cnt0 - b0, 512);
    chk("t4_err_cnt", err_count, 1'b0);

    // Short block, then a good one
    do_reset();
    @(negedge clk);
    chk("t5_to_cleared", err_timeout, 1'b0);
    wait_avail(0, 10, "t5_av0");
    nbytes = 500;
    req(0, 32'h800);
    wait_avail(0, 3000, "t5_av_back");
    chk("t5_err_cnt", err_count, 1'b1);
    chk("t5_err_to", err_timeout, 1'b0);
    nbytes = 512;
    req(0, 32'hA00);
    wait_avail(0, 3000, "t5_av_back2");
    chk("t5_err_sticky", err_count, 1'b1);

    // Reset in the middle of a transfer
    b0 = cnt0; b1 = cnt1;
    req(0, 32'hC00);
    n = 0;
    while (cnt0 - b0 < 50 && n < 300) begin @(negedge clk); n++; end
    req(1, 32'hE00);
    n = 0;
    while (cnt0 - b0 < 100 && n < 300) begin @(negedge clk); n++; end
    chk("t6_pend_pre", pend, 2'b10);
    do_reset();
    @(negedge clk);
    chk("t6_grant", grant, 2'b00);
    chk("t6_pend", pend, 2'b00);
    chk("t6_avail", {c0_available, c1_available}, 2'b00);
    chk("t6_start_addr", {SDctrl_start, SDctrl_address}, 33'h0);
    chk("t6_errs", {err_timeout, err_count}, 2'b00);
    b0 = cnt0; b1 = cnt1; gb = gseq.size();
    n = 0;
    while (sd_busy && n < 1000) begin @(negedge clk); n++; end
    chk("t6_stream_end", sd_busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_no_bytes", {16'(cnt0 - b0), 16'(cnt1 - b1)}, 32'h0);
    chk("t6_no_grant", gseq.size() - gb, 0);
    wait_avail(0, 10, "t6_av0_back");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=1 exp=0");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
